// File: rtl/fsk_zero_if.sv
// Serial-data-in / DAC-out / recovered-bit bundle of the FSK loopback modem.
// The modem core sits on the slave side; the data source and DAC/bit sink sit on the master side.
interface fsk_zero_if;
    logic       data_in;
    logic [7:0] da_data;
    logic       da_clk;
    logic       demodulated_bit;

    modport master (
        output data_in,
        input  da_data,
        input  da_clk,
        input  demodulated_bit
    );

    modport slave (
        input  data_in,
        output da_data,
        output da_clk,
        output demodulated_bit
    );
endinterface

// File: rtl/fsk_zero.sv
// Binary FSK modem: DDS sine modulator for an 8-bit DAC, looped back into a
// zero-crossing period demodulator that recovers the transmitted bit.
module fsk_zero #(
    parameter logic [31:0] FW_MARK    = 32'h051E_B852,
    parameter logic [31:0] FW_SPACE   = 32'h028F_5C29,
    parameter logic [7:0]  MID        = 8'd128,
    parameter logic [7:0]  HYST       = 8'd16,
    parameter logic [15:0] PERIOD_THR = 16'd75,
    parameter logic [15:0] TIMEOUT    = 16'd1000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    fsk_zero_if.slave  bus
);

    // First quadrant of round(127.5 + 127.5*sin(2*pi*p/256)), p = 0..64.
    function automatic logic [7:0] quarter_sine(input logic [6:0] p);
        logic [7:0] q;
        case (p)
            7'd0:  q = 8'd128;  7'd1:  q = 8'd131;  7'd2:  q = 8'd134;  7'd3:  q = 8'd137;
            7'd4:  q = 8'd140;  7'd5:  q = 8'd143;  7'd6:  q = 8'd146;  7'd7:  q = 8'd149;
            7'd8:  q = 8'd152;  7'd9:  q = 8'd155;  7'd10: q = 8'd158;  7'd11: q = 8'd162;
            7'd12: q = 8'd165;  7'd13: q = 8'd167;  7'd14: q = 8'd170;  7'd15: q = 8'd173;
            7'd16: q = 8'd176;  7'd17: q = 8'd179;  7'd18: q = 8'd182;  7'd19: q = 8'd185;
            7'd20: q = 8'd188;  7'd21: q = 8'd190;  7'd22: q = 8'd193;  7'd23: q = 8'd196;
            7'd24: q = 8'd198;  7'd25: q = 8'd201;  7'd26: q = 8'd203;  7'd27: q = 8'd206;
            7'd28: q = 8'd208;  7'd29: q = 8'd211;  7'd30: q = 8'd213;  7'd31: q = 8'd215;
            7'd32: q = 8'd218;  7'd33: q = 8'd220;  7'd34: q = 8'd222;  7'd35: q = 8'd224;
            7'd36: q = 8'd226;  7'd37: q = 8'd228;  7'd38: q = 8'd230;  7'd39: q = 8'd232;
            7'd40: q = 8'd234;  7'd41: q = 8'd235;  7'd42: q = 8'd237;  7'd43: q = 8'd238;
            7'd44: q = 8'd240;  7'd45: q = 8'd241;  7'd46: q = 8'd243;  7'd47: q = 8'd244;
            7'd48: q = 8'd245;  7'd49: q = 8'd246;  7'd50: q = 8'd248;  7'd51: q = 8'd249;
            7'd52: q = 8'd250;  7'd53: q = 8'd250;  7'd54: q = 8'd251;  7'd55: q = 8'd252;
            7'd56: q = 8'd253;  7'd57: q = 8'd253;  7'd58: q = 8'd254;  7'd59: q = 8'd254;
            7'd60: q = 8'd254;  7'd61: q = 8'd255;  7'd62: q = 8'd255;  7'd63: q = 8'd255;
            default: q = 8'd255;
        endcase
        return q;
    endfunction

    // Full 256-entry sine by quadrant symmetry; the negative half mirrors about
    // 127.5, except address 128 which sits exactly on mid-scale like address 0.
    function automatic logic [7:0] sine_rom(input logic [7:0] k);
        logic [6:0] idx;
        logic [6:0] p;
        logic [7:0] q;
        idx = k[6:0];
        p   = (idx <= 7'd64) ? idx : (7'd0 - idx);
        q   = quarter_sine(p);
        if (!k[7])
            return q;
        else if (idx == 7'd0)
            return 8'd128;
        else
            return 8'd255 - q;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == TIMEOUT) ? c : c + 16'd1;
    endfunction

    logic        r_sync_p0;
    logic        r_sync_p1;
    logic [31:0] r_fw_p2;
    logic [31:0] r_acc_p3;
    logic [7:0]  r_da_p4;
    logic [15:0] r_cnt;
    logic        r_armed;
    logic        r_bit;

    logic        w_cross;
    logic        w_low;

    assign w_cross = r_armed && (r_da_p4 >= MID);
    assign w_low   = (r_da_p4 < (MID - HYST));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
            r_fw_p2   <= FW_SPACE;
            r_acc_p3  <= 32'd0;
            r_da_p4   <= 8'd128;
            r_cnt     <= 16'd0;
            r_armed   <= 1'b0;
            r_bit     <= 1'b0;
        end else begin
            // p0/p1: bring data_in into sys_clk
            r_sync_p0 <= bus.data_in;
            r_sync_p1 <= r_sync_p0;
            // p2: tone select
            r_fw_p2   <= r_sync_p1 ? FW_MARK : FW_SPACE;
            // p3: phase accumulator, never cleared so phase stays continuous
            r_acc_p3  <= r_acc_p3 + r_fw_p2;
            // p4: registered sine sample
            r_da_p4   <= sine_rom(r_acc_p3[31:24]);

            // cnt idles at 0 until the first crossing, so the partial first period is never judged
            if (w_cross) begin
                r_armed <= 1'b0;
                if (r_cnt != 16'd0)
                    r_bit <= (r_cnt < PERIOD_THR) && (r_cnt < TIMEOUT);
                r_cnt   <= 16'd1;
            end else begin
                if (w_low)
                    r_armed <= 1'b1;
                if (r_cnt != 16'd0)
                    r_cnt <= sat_inc(r_cnt);
            end
        end
    end

    assign bus.da_data         = r_da_p4;
    assign bus.da_clk          = ~sys_clk;
    assign bus.demodulated_bit = r_bit;

endmodule

// File: tb/tb_fsk_zero.sv
// Self-checking bench for fsk_zero: sine shape, tone periods, bit recovery
// on alternating and random data, phase continuity and mid-stream reset.
`timescale 1ns/1ps
module tb_fsk_zero;

    localparam logic [31:0] FW_SPACE = 32'h028F_5C29;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    fsk_zero_if bus();

    fsk_zero dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #10 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int rom_ref [256];
    int nbit  = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Monitor: step size, min/max and upward mid-scale crossings of the DAC stream
    int  cyc     = 0;
    int  prev_da = 128;
    logic prev_rst = 1'b1;
    int  maxd    = 0;
    int  mn      = 255;
    int  mx      = 0;
    bit  mm_en   = 1'b0;
    bit  rec_en  = 1'b0;
    int  xq [$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        int cur;
        int d;
        cur = int'(bus.da_data);
        if (!sys_rst && !prev_rst) begin
            d = cur - prev_da;
            if (d < 0) d = -d;
            if (d > maxd) maxd <= d;
        end
        if (mm_en) begin
            if (cur < mn) mn <= cur;
            if (cur > mx) mx <= cur;
        end
        if (rec_en && prev_da < 128 && cur >= 128)
            xq.push_back(cyc);
        prev_da  <= cur;
        prev_rst <= sys_rst;
    end

    task automatic check_periods(input string nm, input int lo, input int hi, input int min_n);
        check_eq({nm, "_crossings_enough"}, int'(xq.size() >= min_n), 1);
        for (int j = 1; j < xq.size(); j++) begin
            int d;
            d = xq[j] - xq[j-1];
            check_eq($sformatf("%s_period_in_range_d%0d", nm, d), int'(d >= lo && d <= hi), 1);
        end
    endtask

    // One 500-clock bit; recovered bit must match by 210 clocks and at bit end
    task automatic send_bit(input bit b);
        bus.data_in = b;
        repeat (210) @(posedge sys_clk);
        #1 check_eq($sformatf("bit%0d_mid", nbit), int'(bus.demodulated_bit), int'(b));
        repeat (289) @(posedge sys_clk);
        #1 check_eq($sformatf("bit%0d_end", nbit), int'(bus.demodulated_bit), int'(b));
        @(posedge sys_clk);
        #1;
        nbit++;
    endtask

    task automatic wait_bit_one(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 205 && !found; i++) begin
            @(posedge sys_clk);
            #1;
            if (bus.demodulated_bit === 1'b1) found = 1'b1;
        end
        check_eq(tag, int'(found), 1);
    endtask

    initial begin
        #1800000;
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ph;
        for (int k = 0; k < 256; k++)
            rom_ref[k] = $rtoi($floor(127.5 + 127.5 * $sin(2.0 * 3.141592653589793 * k / 256.0) + 0.5));

        // Reset held 100 ns with data 0
        bus.data_in = 1'b0;
        sys_rst     = 1'b1;
        repeat (5) @(posedge sys_clk);
        #1;
        check_eq("rst_da_data", int'(bus.da_data), 128);
        check_eq("rst_bit", int'(bus.demodulated_bit), 0);
        sys_rst = 1'b0;

        // Space tone from phase 0: sample after edge i is sin of phase (i-1)*FW_SPACE
        for (int i = 1; i <= 100; i++) begin
            @(posedge sys_clk);
            #1;
            ph = FW_SPACE * 32'(i - 1);
            check_eq($sformatf("dds_space_%0d", i), int'(bus.da_data), rom_ref[ph[31:24]]);
        end
        xq.delete();
        mm_en  = 1'b1;
        rec_en = 1'b1;
        repeat (900) @(posedge sys_clk);
        #1;
        mm_en  = 1'b0;
        rec_en = 1'b0;
        check_eq("space_bit", int'(bus.demodulated_bit), 0);
        check_eq("space_min", mn, 0);
        check_eq("space_max", mx, 255);
        check_periods("space", 99, 101, 8);

        // Constant mark
        bus.data_in = 1'b1;
        wait_bit_one("mark_within_205");
        xq.delete();
        rec_en = 1'b1;
        repeat (400) @(posedge sys_clk);
        #1;
        rec_en = 1'b0;
        check_eq("mark_bit", int'(bus.demodulated_bit), 1);
        check_periods("mark", 49, 51, 7);

        // Alternating bits
        for (int i = 0; i < 20; i++)
            send_bit(i[0]);

        // Random bits
        for (int i = 0; i < 60; i++)
            send_bit(1'($urandom_range(0, 1)));

        // Reset pulse mid-stream during a mark bit
        bus.data_in = 1'b1;
        repeat (200) @(posedge sys_clk);
        #1;
        check_eq("pre_reset_bit", int'(bus.demodulated_bit), 1);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check_eq("midrst_da_data", int'(bus.da_data), 128);
        check_eq("midrst_bit", int'(bus.demodulated_bit), 0);
        sys_rst = 1'b0;
        wait_bit_one("recover_within_205");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);

        // Phase continuity over the whole run, including every tone switch
        check_eq("max_step_le_17", int'(maxd <= 17), 1);
        check_eq("max_step_seen_ge_14", int'(maxd >= 14), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
